// File: rtl/conv_pkg.sv
// Purpose: shared types and constants for the convolution index sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package conv_pkg;

   localparam int AW_DEF  = 5;
   localparam int ZAW_DEF = AW_DEF + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Highest output index n for a job with lengths sx, sy (both nonzero).
   function automatic int n_limit(input int sx, input int sy);
      return sx + sy - 2;
   endfunction

endpackage

// File: rtl/convolution_processor_nk_counter.sv
// Purpose: nested tap (k, inner) / output (n, outer) counter with wrap and last flags.
// Latency: counts update on the clock edge after clear_i or step_i.
// Backpressure: advances only when step_i is high; holds otherwise.
// Ports: clear_i zeroes n and k; step_i advances; sx_i tap count; n_max_i final n;
//        k_o/n_o current indices; k_last_o/n_last_o flag the final tap / final n.
module convolution_processor_nk_counter
   import conv_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int ZAW = AW + 1
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           clear_i,
   input  logic           step_i,
   input  logic [AW:0]    sx_i,
   input  logic [ZAW-1:0] n_max_i,
   output logic [AW-1:0]  k_o,
   output logic [ZAW-1:0] n_o,
   output logic           k_last_o,
   output logic           n_last_o
);

   localparam logic [AW:0]    ONE_X = 1;
   localparam logic [AW-1:0]  ONE_K = 1;
   localparam logic [ZAW-1:0] ONE_N = 1;

   logic [AW-1:0]  k_q, k_d;
   logic [ZAW-1:0] n_q, n_d;

   // k is AW bits but SX can be 2**AW, so compare in AW+1 bits.
   assign k_last_o = ({1'b0, k_q} == (sx_i - ONE_X));
   assign n_last_o = (n_q == n_max_i);
   assign k_o      = k_q;
   assign n_o      = n_q;

   always_comb begin
      k_d = k_q;
      n_d = n_q;
      if (clear_i) begin
         k_d = '0;
         n_d = '0;
      end else if (step_i) begin
         if (k_last_o) begin
            k_d = '0;
            // On the final pair n holds; the FSM leaves ISSUE instead.
            if (!n_last_o) begin
               n_d = n_q + ONE_N;
            end
         end else begin
            k_d = k_q + ONE_K;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         k_q <= '0;
         n_q <= '0;
      end else begin
         k_q <= k_d;
         n_q <= n_d;
      end
   end

endmodule

// File: rtl/convolution_processor_index_sequencer.sv
// Purpose: walks n and k for z[n] = sum_k x[k]*y[n-k], emitting X/Y addresses plus a validity mask.
// Latency: first pair valid the cycle after start; one pair per clock while ready; done_o one cycle after final transfer.
// Backpressure: valid/ready; all pair outputs hold until valid & ready.
// Ports: start_i/size_x_i/size_y_i launch a job; busy_o/done_o report status;
//        pair_valid_o/pair_ready_i handshake memx_addr_o, memy_addr_o, pair_mask_o, pair_last_o, z_idx_o.
module convolution_processor_index_sequencer
   import conv_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int ZAW = AW + 1
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           start_i,
   input  logic [AW:0]    size_x_i,
   input  logic [AW:0]    size_y_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           pair_valid_o,
   input  logic           pair_ready_i,
   output logic [AW-1:0]  memx_addr_o,
   output logic [AW-1:0]  memy_addr_o,
   output logic           pair_mask_o,
   output logic           pair_last_o,
   output logic [ZAW-1:0] z_idx_o
);

   state_e         state_q;
   logic [AW:0]    sx_q, sy_q;
   logic           busy_q, done_q, valid_q;

   logic           accept, zero_len, xfer;
   logic [ZAW-1:0] n_max;
   logic [AW-1:0]  k;
   logic [ZAW-1:0] n;
   logic           k_last, n_last;
   logic [AW+1:0]  j;
   logic           mask;

   assign accept   = (state_q == IDLE) && start_i;
   assign zero_len = (size_x_i == '0) || (size_y_i == '0);
   assign xfer     = valid_q && pair_ready_i;
   assign n_max    = ZAW'(n_limit(int'(sx_q), int'(sy_q)));

   convolution_processor_nk_counter #(
      .AW  (AW),
      .ZAW (ZAW)
   ) u_nk (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clear_i  (accept),
      .step_i   (xfer),
      .sx_i     (sx_q),
      .n_max_i  (n_max),
      .k_o      (k),
      .n_o      (n),
      .k_last_o (k_last),
      .n_last_o (n_last)
   );

   // j = n - k in AW+2 bits: MSB is the sign, low AW+1 bits are the magnitude
   // when non-negative, so the unsigned compare against SY is only trusted after the sign test.
   assign j    = {1'b0, n} - {2'b00, k};
   assign mask = ~j[AW+1] & (j[AW:0] < sy_q);

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pair_valid_o = valid_q;
   assign memx_addr_o  = valid_q ? k : '0;
   assign memy_addr_o  = (valid_q && mask) ? j[AW-1:0] : '0;
   assign pair_mask_o  = valid_q && mask;
   assign pair_last_o  = valid_q && k_last;
   assign z_idx_o      = valid_q ? n : '0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         sx_q    <= '0;
         sy_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  sx_q   <= size_x_i;
                  sy_q   <= size_y_i;
                  busy_q <= 1'b1;
                  if (zero_len) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ISSUE;
                     valid_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (xfer && k_last && n_last) begin
                  state_q <= DONE;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
